cv32e40px_x_disp_mo: RTL

- Next-generation X-interface dispatcher in the ID stage. Supports up to MAX_OUTSTANDING offloaded instructions in flight, with out-of-order result return matched by ID.
- Can defer the commit of speculatively issued instructions until the core resolves them, then commits or kills them.
- Owns the register scoreboard, in-flight table, ID allocation and core stall for offloaded instructions.

---
 rtl/cv32e40px_x_disp_mo.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40px_x_disp_mo.sv
// cv32e40px_x_disp_mo
//   X-interface dispatcher for the ID stage. Keeps up to MAX_OUTSTANDING
//   offloaded instructions in flight and matches out-of-order results by ID.
//   Owns the register scoreboard, the in-flight table, ID allocation, commit
//   sequencing (including deferred commit of speculative issues) and the
//   offload stall towards the core.
//
//   Ports:
//     clk_i, rst_ni            clock, synchronous active-low reset
//     instr_valid_i ...        ID-stage instruction info (offload, speculative,
//                              sources, destination, id_ready_i)
//     resolve_valid/kill_i     branch resolution for a deferred commit
//     x_issue_*                issue request / response
//     x_commit_*               commit strobe, ID and kill
//     x_result_*               result return, write-back enable, miss error
//     x_stall_o                stall ID while an offload waits to issue
//     x_illegal_insn_o         offload rejected by the coprocessor
//     outstanding_o            number of valid in-flight entries
//
//   Optional feature: define CV32E40PX_X_DISP_TIMEOUT_EN to add a per-entry
//   age watchdog that force-frees an entry after TIMEOUT_CYCLES.
module cv32e40px_x_disp_mo #(
  parameter int X_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int X_NUM_RS        = 3,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   instr_valid_i,
  input  logic                                   x_offload_i,
  input  logic                                   speculative_i,
  input  logic                                   resolve_valid_i,
  input  logic                                   resolve_kill_i,
  input  logic                                   id_ready_i,
  input  logic [X_NUM_RS*5-1:0]                  x_rs_addr_i,
  input  logic [X_NUM_RS-1:0]                    regs_used_i,
  input  logic [4:0]                             waddr_id_i,
  output logic                                   x_issue_valid_o,
  input  logic                                   x_issue_ready_i,
  input  logic                                   x_issue_resp_accept_i,
  input  logic                                   x_issue_resp_writeback_i,
  output logic [X_ID_WIDTH-1:0]                  x_issue_req_id_o,
  output logic [X_NUM_RS-1:0]                    x_issue_req_rs_valid_o,
  output logic                                   x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0]                  x_commit_id_o,
  output logic                                   x_commit_kill_o,
  input  logic                                   x_result_valid_i,
  output logic                                   x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]                  x_result_id_i,
  input  logic                                   x_result_we_i,
  output logic                                   x_result_wb_en_o,
  output logic                                   x_result_err_o,
  output logic                                   x_stall_o,
  output logic                                   x_illegal_insn_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [MAX_OUTSTANDING-1:0] tbl_valid_q, tbl_valid_d;
  logic [MAX_OUTSTANDING-1:0] tbl_we_q, tbl_we_d;
  logic [MAX_OUTSTANDING-1:0] tbl_committed_q, tbl_committed_d;
  logic [MAX_OUTSTANDING-1:0] tbl_killed_q, tbl_killed_d;
  logic [X_ID_WIDTH-1:0]      tbl_id_q [MAX_OUTSTANDING];
  logic [X_ID_WIDTH-1:0]      tbl_id_d [MAX_OUTSTANDING];
  logic [4:0]                 tbl_rd_q [MAX_OUTSTANDING];
  logic [4:0]                 tbl_rd_d [MAX_OUTSTANDING];
  logic [31:0]                scoreboard_q, scoreboard_d;
  logic [X_ID_WIDTH-1:0]      next_id_q, next_id_d;
  logic                       commit_pending_q, commit_pending_d;
  logic [X_ID_WIDTH-1:0]      pending_id_q, pending_id_d;
  logic [IDX_W-1:0]           pending_slot_q, pending_slot_d;
  logic                       offloaded_q, offloaded_d;

  logic                       hit, id_busy, free_found, hazard, res_hit;
  logic [IDX_W-1:0]           hit_idx, alloc_idx, commit_slot;
  logic                       offload_req, handshake, accepted;
  logic                       commit_mark, pend_set;
  logic [MAX_OUTSTANDING-1:0] expire, expire_eff;
  logic [CNT_W-1:0]           count;
  logic                       unused_committed;

  // committed is carried for debug visibility; no logic consumes it
  assign unused_committed = ^tbl_committed_q;

  // Table lookups: result match, wrap collision on the next ID, lowest free slot
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    id_busy    = 1'b0;
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (tbl_valid_q[i] && (tbl_id_q[i] == x_result_id_i) && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (tbl_valid_q[i] && (tbl_id_q[i] == next_id_q)) id_busy = 1'b1;
      if (!tbl_valid_q[i] && !free_found) begin
        free_found = 1'b1;
        alloc_idx  = IDX_W'(i);
      end
    end
  end

  // RAW on used sources and WAW on a nonzero destination
  always_comb begin
    hazard                 = (waddr_id_i != 5'd0) && scoreboard_q[waddr_id_i];
    x_issue_req_rs_valid_o = '0;
    for (int i = 0; i < X_NUM_RS; i++) begin
      if (regs_used_i[i] && scoreboard_q[x_rs_addr_i[i*5 +: 5]]) hazard = 1'b1;
      x_issue_req_rs_valid_o[i] = instr_valid_i & x_offload_i & ~scoreboard_q[x_rs_addr_i[i*5 +: 5]];
    end
  end

  assign offload_req      = instr_valid_i & x_offload_i & ~offloaded_q;
  assign x_issue_valid_o  = offload_req & free_found & ~id_busy & ~commit_pending_q & ~hazard;
  assign handshake        = x_issue_valid_o & x_issue_ready_i;
  assign accepted         = handshake & x_issue_resp_accept_i;
  assign x_illegal_insn_o = handshake & ~x_issue_resp_accept_i;
  assign x_stall_o        = offload_req & ~handshake;
  assign x_issue_req_id_o = next_id_q;
  assign x_result_ready_o = 1'b1;
  assign res_hit          = x_result_valid_i & hit;
  assign x_result_wb_en_o = res_hit & x_result_we_i & ~tbl_killed_q[hit_idx];
  assign x_result_err_o   = (x_result_valid_i & ~hit) | (|expire_eff);

  // A pending resolve cannot coincide with a new handshake because pending blocks issue
  always_comb begin
    x_commit_valid_o = 1'b0;
    x_commit_id_o    = '0;
    x_commit_kill_o  = 1'b0;
    commit_mark      = 1'b0;
    commit_slot      = alloc_idx;
    pend_set         = 1'b0;
    if (commit_pending_q && resolve_valid_i) begin
      x_commit_valid_o = 1'b1;
      x_commit_id_o    = pending_id_q;
      x_commit_kill_o  = resolve_kill_i;
      commit_mark      = 1'b1;
      commit_slot      = pending_slot_q;
    end else if (accepted) begin
      if (!speculative_i || resolve_valid_i) begin
        x_commit_valid_o = 1'b1;
        x_commit_id_o    = next_id_q;
        x_commit_kill_o  = speculative_i & resolve_kill_i;
        commit_mark      = 1'b1;
      end else begin
        pend_set = 1'b1;
      end
    end
  end

  // Result hit wins over a watchdog expiry on the same slot
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      expire_eff[i] = expire[i] & ~(res_hit & (hit_idx == IDX_W'(i)));
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) count = count + CNT_W'(tbl_valid_q[i]);
  end
  assign outstanding_o = count;

  // Next state: free on result/expiry, allocate, then commit/kill effects
  always_comb begin
    tbl_valid_d      = tbl_valid_q;
    tbl_we_d         = tbl_we_q;
    tbl_committed_d  = tbl_committed_q;
    tbl_killed_d     = tbl_killed_q;
    tbl_id_d         = tbl_id_q;
    tbl_rd_d         = tbl_rd_q;
    scoreboard_d     = scoreboard_q;
    next_id_d        = next_id_q;
    commit_pending_d = commit_pending_q;
    pending_id_d     = pending_id_q;
    pending_slot_d   = pending_slot_q;
    offloaded_d      = id_ready_i ? 1'b0 : (accepted | offloaded_q);

    if (res_hit) begin
      tbl_valid_d[hit_idx] = 1'b0;
      if (tbl_we_q[hit_idx] && !tbl_killed_q[hit_idx]) scoreboard_d[tbl_rd_q[hit_idx]] = 1'b0;
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (expire_eff[i]) begin
        tbl_valid_d[i] = 1'b0;
        if (tbl_we_q[i] && !tbl_killed_q[i]) scoreboard_d[tbl_rd_q[i]] = 1'b0;
      end
    end
    if (accepted) begin
      tbl_valid_d[alloc_idx]     = 1'b1;
      tbl_id_d[alloc_idx]        = next_id_q;
      tbl_rd_d[alloc_idx]        = waddr_id_i;
      tbl_we_d[alloc_idx]        = x_issue_resp_writeback_i;
      tbl_committed_d[alloc_idx] = 1'b0;
      tbl_killed_d[alloc_idx]    = 1'b0;
      if (x_issue_resp_writeback_i) scoreboard_d[waddr_id_i] = 1'b1;
    end
    if (handshake) next_id_d = next_id_q + 1'b1;
    // an entry already freed by its result this cycle is left alone
    if (commit_mark && tbl_valid_d[commit_slot]) begin
      tbl_committed_d[commit_slot] = 1'b1;
      if (x_commit_kill_o) begin
        tbl_killed_d[commit_slot] = 1'b1;
        if (tbl_we_d[commit_slot]) scoreboard_d[tbl_rd_d[commit_slot]] = 1'b0;
      end
    end
    if (commit_pending_q && resolve_valid_i) begin
      commit_pending_d = 1'b0;
    end else if (pend_set) begin
      commit_pending_d = 1'b1;
      pending_id_d     = next_id_q;
      pending_slot_d   = alloc_idx;
    end
    scoreboard_d[0] = 1'b0;
  end

`ifdef CV32E40PX_X_DISP_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [AGE_W-1:0] age_q [MAX_OUTSTANDING];
  logic [AGE_W-1:0] age_d [MAX_OUTSTANDING];

  // Age counts valid cycles; a free slot sits at zero so allocation restarts it
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      expire[i] = tbl_valid_q[i] && (age_q[i] == AGE_W'(TIMEOUT_CYCLES));
      if (!tbl_valid_q[i])  age_d[i] = '0;
      else if (!expire[i])  age_d[i] = age_q[i] + 1'b1;
      else                  age_d[i] = age_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) age_q[i] <= rst_ni ? age_d[i] : '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tbl_valid_q      <= '0;
      tbl_we_q         <= '0;
      tbl_committed_q  <= '0;
      tbl_killed_q     <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tbl_id_q[i] <= '0;
        tbl_rd_q[i] <= '0;
      end
      scoreboard_q     <= '0;
      next_id_q        <= '0;
      commit_pending_q <= 1'b0;
      pending_id_q     <= '0;
      pending_slot_q   <= '0;
      offloaded_q      <= 1'b0;
    end else begin
      tbl_valid_q      <= tbl_valid_d;
      tbl_we_q         <= tbl_we_d;
      tbl_committed_q  <= tbl_committed_d;
      tbl_killed_q     <= tbl_killed_d;
      tbl_id_q         <= tbl_id_d;
      tbl_rd_q         <= tbl_rd_d;
      scoreboard_q     <= scoreboard_d;
      next_id_q        <= next_id_d;
      commit_pending_q <= commit_pending_d;
      pending_id_q     <= pending_id_d;
      pending_slot_q   <= pending_slot_d;
      offloaded_q      <= offloaded_d;
    end
  end

endmodule
